// File: rtl/bus_lsu_if.sv
// Bus-side signal bundle for bus_lsu: a two-phase SEL/ENABLE handshake with READY wait states.
// master = LSU side, slave = memory/peripheral side.
interface bus_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   ADDR;
  logic                SEL;
  logic                ENABLE;
  logic                WRITE;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] STRB;
  logic                READY;
  logic [DATA_W-1:0]   RDATA;
  logic                SLVERR;

  modport master (
    output ADDR, SEL, ENABLE, WRITE, WDATA, STRB,
    input  READY, RDATA, SLVERR
  );

  modport slave (
    input  ADDR, SEL, ENABLE, WRITE, WDATA, STRB,
    output READY, RDATA, SLVERR
  );
endinterface

// File: rtl/bus_lsu.sv
// Load/store unit: turns one core memory request into a SETUP/ACCESS bus transfer.
// Optional ACCESS watchdog is compiled in with `define LSU_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for transfer; latches request or flags an alignment fault
// SETUP  | SEL=1, ENABLE=0 for one cycle
// ACCESS | SEL=1, ENABLE=1 until READY (or watchdog expiry)
// DONE   | one-cycle ack, err and load writeback
module bus_lsu #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              transfer,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic              stall,
  output logic              ack,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  bus_lsu_if.master         bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LB     = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic              op_write;
  logic [1:0]        op_size;
  logic              op_signed;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [STRB_W-1:0] op_strb;
  logic [REG_AW-1:0] op_rd;
  logic              op_err;
  logic [DATA_W-1:0] wb_data_q;

  logic              misaligned;
  logic [DATA_W-1:0] lane_wdata;
  logic [STRB_W-1:0] lane_strb;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] rd_mask;
  logic              rd_sign;
  logic [DATA_W-1:0] rd_ext;
  logic              timeout;

  always_comb begin
    misaligned = 1'b0;
    lane_wdata = req_wdata;
    lane_strb  = '1;
    case (req_size)
      2'd0: begin
        lane_wdata = {(DATA_W/8){req_wdata[7:0]}};
        lane_strb  = STRB_W'(1) << req_addr[LB-1:0];
      end
      2'd1: begin
        misaligned = req_addr[0];
        lane_wdata = {(DATA_W/16){req_wdata[15:0]}};
        lane_strb  = STRB_W'(3) << req_addr[LB-1:0];
      end
      2'd2: begin
        misaligned = |req_addr[1:0];
        lane_wdata = {(DATA_W/32){req_wdata[31:0]}};
        lane_strb  = STRB_W'(15) << req_addr[LB-1:0];
      end
      default: begin
        // dword only exists on a 64-bit bus
        misaligned = (DATA_W == 32) || (|req_addr[2:0]);
        lane_wdata = req_wdata;
        lane_strb  = '1;
      end
    endcase
  end

  always_comb begin
    rd_shifted = bus.RDATA >> {op_addr[LB-1:0], 3'b000};
    rd_mask    = '1;
    rd_sign    = 1'b0;
    case (op_size)
      2'd0:    begin rd_mask = DATA_W'(8'hFF);          rd_sign = rd_shifted[7];  end
      2'd1:    begin rd_mask = DATA_W'(16'hFFFF);       rd_sign = rd_shifted[15]; end
      2'd2:    begin rd_mask = DATA_W'(32'hFFFF_FFFF);  rd_sign = rd_shifted[31]; end
      default: begin rd_mask = '1;                      rd_sign = 1'b0;           end
    endcase
    // a native-width load has an all-ones mask, so extension is a no-op
    rd_ext = (rd_shifted & rd_mask) | ((op_signed && rd_sign) ? ~rd_mask : '0);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign timeout = (state == ACCESS) && !bus.READY && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      to_cnt <= '0;
    else if (state == ACCESS && !bus.READY)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = misaligned ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.READY || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      op_size   <= 2'd0;
      op_signed <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      op_strb   <= '0;
      op_rd     <= '0;
      op_err    <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && transfer) begin
        op_write  <= req_write;
        op_size   <= req_size;
        op_signed <= req_signed;
        op_addr   <= req_addr;
        op_wdata  <= req_write ? lane_wdata : '0;
        op_strb   <= req_write ? lane_strb : '0;
        op_rd     <= req_rd;
        op_err    <= misaligned;
      end
      if (state == ACCESS) begin
        if (bus.READY) begin
          op_err <= bus.SLVERR;
          if (!op_write) wb_data_q <= rd_ext;
        end else if (timeout) begin
          op_err <= 1'b1;
        end
      end
    end
  end

  assign bus.ADDR   = op_addr;
  assign bus.SEL    = (state == SETUP) || (state == ACCESS);
  assign bus.ENABLE = (state == ACCESS);
  assign bus.WRITE  = op_write;
  assign bus.WDATA  = op_wdata;
  assign bus.STRB   = op_strb;

  assign ack     = (state == DONE);
  assign err     = ack && op_err;
  assign wb_en   = ack && !op_write && !op_err;
  assign wb_rd   = op_rd;
  assign wb_data = wb_data_q;
  assign stall   = transfer && !ack;

endmodule

// File: tb/tb_bus_lsu.sv
// Directed bench for bus_lsu (32-bit bus): table of single ops plus wait-state, drop, reset
// and (when LSU_TIMEOUT_EN is defined) watchdog sequences.
module tb_bus_lsu;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        transfer;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall, ack, wb_en, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_vec  = 0;
  int n_fail = 0;

  bus_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  bus_lsu #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .transfer(transfer), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .ack(ack),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    logic        fault;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v, input logic [4:0] rd);
    @(negedge CLK);
    transfer = 1'b1; req_write = v.write; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = rd;
    bus.READY = 1'b0; bus.SLVERR = 1'b0;
    #1 chk("stall_idle", stall, 1);
    @(negedge CLK);
    if (v.fault) begin
      chk("fault_sel", bus.SEL, 0);
      chk("fault_ack", ack, 1);
      chk("fault_err", err, 1);
      chk("fault_wb_en", wb_en, 0);
      transfer = 1'b0;
      @(negedge CLK);
      chk("fault_ack_clr", ack, 0);
      return;
    end
    chk("setup_sel", bus.SEL, 1);
    chk("setup_enable", bus.ENABLE, 0);
    chk("setup_addr", bus.ADDR, v.addr);
    chk("setup_write", bus.WRITE, v.write);
    chk("setup_wdata", bus.WDATA, v.exp_wdata);
    chk("setup_strb", bus.STRB, v.exp_strb);
    chk("setup_stall", stall, 1);
    bus.READY = 1'b1; bus.RDATA = v.rdata; bus.SLVERR = v.slverr;
    @(negedge CLK);
    chk("access_enable", bus.ENABLE, 1);
    chk("access_sel", bus.SEL, 1);
    chk("access_wdata", bus.WDATA, v.exp_wdata);
    @(negedge CLK);
    chk("done_ack", ack, 1);
    chk("done_stall", stall, 0);
    chk("done_sel", bus.SEL, 0);
    chk("done_err", err, v.slverr);
    chk("done_wb_en", wb_en, !v.write && !v.slverr);
    if (!v.write && !v.slverr) begin
      chk("done_wb_data", wb_data, v.exp_wb);
      chk("done_wb_rd", wb_rd, rd);
    end
    transfer = 1'b0; bus.READY = 1'b0; bus.SLVERR = 1'b0;
    @(negedge CLK);
    chk("idle_ack", ack, 0);
    chk("idle_enable", bus.ENABLE, 0);
  endtask

  initial begin
    //           wr    sz    sg    addr          wdata         rdata         se    flt   exp_wdata     strb     exp_wb
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'h8899AABB, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h8899AABB};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,         32'h80112233, 1'b0, 1'b0, 32'h0,         4'b0000, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,         32'h80112233, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h00000080};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD,  32'h0,        1'b0, 1'b0, 32'hABCDABCD,  4'b1100, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,         32'h0,        1'b0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5,  32'h0,        1'b0, 1'b0, 32'hA5A5A5A5,  4'b0010, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,         32'h12348001, 1'b0, 1'b0, 32'h0,         4'b0000, 32'hFFFF8001};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,         32'hFEDC0000, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0000FEDC};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF,  4'b1111, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h108, 32'h0,         32'h0,        1'b0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h103, 32'h0,         32'h0,        1'b0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,         32'h00000001, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h102, 32'h0,         32'h007F0000, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0000007F};

    RESETn = 1'b0; transfer = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    bus.READY = 1'b0; bus.RDATA = '0; bus.SLVERR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_sel", bus.SEL, 0);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_strb", bus.STRB, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wb_data", wb_data, 0);
    transfer = 1'b1;
    #1 chk("rst_stall", stall, 1);
    transfer = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;

    for (int i = 0; i < 13; i++) run_op(vecs[i], 5'(i + 1));

    // wait states then slave error
    @(negedge CLK);
    transfer = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h180; req_wdata = 32'h5A5A0F0F; req_rd = 5'd9;
    @(negedge CLK);
    chk("ws_setup_sel", bus.SEL, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk("ws_enable", bus.ENABLE, 1);
      chk("ws_addr", bus.ADDR, 32'h180);
      chk("ws_wdata", bus.WDATA, 32'h5A5A0F0F);
      chk("ws_strb", bus.STRB, 4'b1111);
      chk("ws_no_ack", ack, 0);
      if (k == 4) begin bus.READY = 1'b1; bus.SLVERR = 1'b1; end
    end
    @(negedge CLK);
    chk("ws_ack", ack, 1);
    chk("ws_err", err, 1);
    chk("ws_wb_en", wb_en, 0);
    transfer = 1'b0; bus.READY = 1'b0; bus.SLVERR = 1'b0;

    // transfer dropped mid-op still completes
    @(negedge CLK);
    transfer = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h140; req_rd = 5'd17;
    @(negedge CLK);
    transfer = 1'b0; bus.READY = 1'b1; bus.RDATA = 32'hCAFEF00D;
    chk("drop_sel", bus.SEL, 1);
    @(negedge CLK);
    chk("drop_enable", bus.ENABLE, 1);
    @(negedge CLK);
    chk("drop_ack", ack, 1);
    chk("drop_wb_en", wb_en, 1);
    chk("drop_wb_data", wb_data, 32'hCAFEF00D);
    chk("drop_wb_rd", wb_rd, 17);
    chk("drop_stall", stall, 0);
    bus.READY = 1'b0;

    // reset mid-ACCESS
    @(negedge CLK);
    transfer = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h1C0; req_rd = 5'd3;
    repeat (2) @(negedge CLK);
    chk("rstx_enable_before", bus.ENABLE, 1);
    RESETn = 1'b0;
    #1;
    chk("rstx_sel", bus.SEL, 0);
    chk("rstx_enable", bus.ENABLE, 0);
    chk("rstx_ack", ack, 0);
    chk("rstx_wb_en", wb_en, 0);
    chk("rstx_stall", stall, 1);
    transfer = 1'b0;
    @(negedge CLK);
    chk("rstx_hold_ack", ack, 0);
    RESETn = 1'b1;
    run_op(vecs[0], 5'd4);

`ifdef LSU_TIMEOUT_EN
    begin
      int acc_cycles;
      bit seen_ack;
      acc_cycles = 0;
      seen_ack = 1'b0;
      @(negedge CLK);
      transfer = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300; req_rd = 5'd6;
      bus.READY = 1'b0;
      for (int c = 0; c < 20 && !seen_ack; c++) begin
        @(negedge CLK);
        if (bus.ENABLE) acc_cycles++;
        if (ack) begin
          seen_ack = 1'b1;
          chk("to_err", err, 1);
          chk("to_wb_en", wb_en, 0);
          chk("to_sel", bus.SEL, 0);
        end
      end
      chk("to_seen_ack", seen_ack, 1);
      chk("to_access_cycles", acc_cycles, 4);
      transfer = 1'b0;
      @(negedge CLK);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
